// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b computed LSB first through one
// full-subtractor cell, with the difference and flags presented on a done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is a request taken on any rising edge where state is
  // IDLE or DONE; done is a single-cycle pulse and diff/flags are valid with it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    count_q, count_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic             ai, bi, d_bit, borrow_nx;
  logic [WIDTH-1:0] res_nx;

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    count_d      = count_q;
    borrow_d     = borrow_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;
    zero_d       = zero_q;

    ai        = a_sh_q[0];
    bi        = b_sh_q[0];
    d_bit     = ai ^ bi ^ borrow_q;
    borrow_nx = (~ai & bi) | (~(ai ^ bi) & borrow_q);
    res_nx    = {d_bit, res_q[WIDTH-1:1]};

    case (state_q)
      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_d    = res_nx;
        borrow_d = borrow_nx;
        count_d  = count_q + 1'b1;
        if (count_q == LAST) begin
          // Results load from the in-flight values so the last bit is included.
          state_d      = DONE;
          diff_d       = res_nx;
          borrow_out_d = borrow_nx;
          overflow_d   = (a_msb_q != b_msb_q) && (res_nx[WIDTH-1] != a_msb_q);
          zero_d       = (res_nx == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d  = SHIFT;
      a_sh_d   = a;
      b_sh_d   = b;
      res_d    = '0;
      count_d  = '0;
      borrow_d = 1'b0;
      a_msb_d  = a[WIDTH-1];
      b_msb_d  = b[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      count_q      <= '0;
      borrow_q     <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      count_q      <= count_d;
      borrow_q     <= borrow_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
      zero_q       <= zero_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;
  assign zero       = zero_q;

endmodule
